// File: rtl/snn_if.sv
// Configuration and observation bundle of the single-synapse SNN demonstrator.
// The master drives pixel, weights, thresholds, leaks and refractory lengths.
// The slave returns the encoder, LFSR and neuron state.
interface snn_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] pixel_value;
    logic [WIDTH-1:0] weight1;
    logic [WIDTH-1:0] weight2;
    logic [WIDTH-1:0] threshold1;
    logic [WIDTH-1:0] threshold2;
    logic [WIDTH-1:0] leak_value1;
    logic [WIDTH-1:0] leak_value2;
    logic [7:0]       tref1;
    logic [7:0]       tref2;
    logic [WIDTH-1:0] memb_potential_out1;
    logic [WIDTH-1:0] memb_potential_out2;
    logic             spike_out1;
    logic             spike_out2;
    logic [7:0]       tr1;
    logic [7:0]       tr2;
    logic             spike_train;
    logic [WIDTH-1:0] random_number;

    modport master (
        output pixel_value, weight1, weight2, threshold1, threshold2,
               leak_value1, leak_value2, tref1, tref2,
        input  memb_potential_out1, memb_potential_out2, spike_out1, spike_out2,
               tr1, tr2, spike_train, random_number
    );

    modport slave (
        input  pixel_value, weight1, weight2, threshold1, threshold2,
               leak_value1, leak_value2, tref1, tref2,
        output memb_potential_out1, memb_potential_out2, spike_out1, spike_out2,
               tr1, tr2, spike_train, random_number
    );
endinterface

// File: rtl/snn_system.sv
// Rate encoder (LFSR compared against pixel) feeding two LIF neurons in series.
// Neuron 2 is driven by neuron 1's registered spike.
module snn_system #(
    parameter int             WIDTH     = 16,
    parameter logic [WIDTH-1:0] LFSR_SEED = 16'hACE1
) (
    input logic  clk,
    input logic  rst,
    snn_if.slave bus
);
    typedef struct packed {
        logic [WIDTH-1:0] pot;
        logic             spike;
        logic [7:0]       tr;
    } lif_t;

    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    lif_t             n1_q, n1_d;
    lif_t             n2_q, n2_d;
    logic             spikeTrain;

    // Saturating leaky integrate; refractory cycles hold the potential at zero.
    function automatic lif_t lifNext(
        input lif_t             cur,
        input logic             spikeIn,
        input logic [WIDTH-1:0] weight,
        input logic [WIDTH-1:0] leak,
        input logic [WIDTH-1:0] thr,
        input logic [7:0]       tref
    );
        lif_t           nxt;
        logic [WIDTH:0] a;
        logic [WIDTH:0] b;
        logic [WIDTH-1:0] v;
        a = {1'b0, cur.pot} + (spikeIn ? {1'b0, weight} : '0);
        b = (a > {1'b0, leak}) ? a - {1'b0, leak} : '0;
        v = b[WIDTH] ? '1 : b[WIDTH-1:0];
        nxt.pot   = '0;
        nxt.spike = 1'b0;
        nxt.tr    = '0;
        if (cur.tr != 8'd0) begin
            nxt.tr = cur.tr - 8'd1;
        end else if (v >= thr) begin
            nxt.spike = 1'b1;
            nxt.tr    = tref;
        end else begin
            nxt.pot = v;
        end
        return nxt;
    endfunction

    assign spikeTrain = (lfsr_q <= bus.pixel_value);

    always_comb begin
        lfsr_d = {lfsr_q[WIDTH-2:0],
                  lfsr_q[WIDTH-1] ^ lfsr_q[WIDTH-3] ^ lfsr_q[WIDTH-4] ^ lfsr_q[WIDTH-6]};
        n1_d   = lifNext(n1_q, spikeTrain, bus.weight1, bus.leak_value1,
                         bus.threshold1, bus.tref1);
        n2_d   = lifNext(n2_q, n1_q.spike, bus.weight2, bus.leak_value2,
                         bus.threshold2, bus.tref2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
            n1_q   <= '0;
            n2_q   <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            n1_q   <= n1_d;
            n2_q   <= n2_d;
        end
    end

    assign bus.random_number       = lfsr_q;
    assign bus.spike_train         = spikeTrain;
    assign bus.memb_potential_out1 = n1_q.pot;
    assign bus.memb_potential_out2 = n2_q.pot;
    assign bus.spike_out1          = n1_q.spike;
    assign bus.spike_out2          = n2_q.spike;
    assign bus.tr1                 = n1_q.tr;
    assign bus.tr2                 = n2_q.tr;
endmodule

// File: tb/tb_snn_system.sv
// Scoreboard bench for snn_system.
// Stimulus pushes hand-computed expectations per edge; a monitor pops and compares them.
module tb_snn_system;
    logic clk = 1'b0;
    logic rst;

    snn_if #(.WIDTH(16)) bus ();

    snn_system #(.WIDTH(16), .LFSR_SEED(16'hACE1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        cRnd; logic [15:0] rnd;
        logic        cSt;  logic        st;
        logic        cMp1; logic [15:0] mp1;
        logic        cS1;  logic        s1;
        logic        cTr1; logic [7:0]  tr1;
        logic        cMp2; logic [15:0] mp2;
        logic        cS2;  logic        s2;
        logic        cTr2; logic [7:0]  tr2;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    function automatic exp_t expN1(exp_t e, logic [15:0] mp, logic s, logic [7:0] tr);
        e.cMp1 = 1'b1; e.mp1 = mp;
        e.cS1  = 1'b1; e.s1  = s;
        e.cTr1 = 1'b1; e.tr1 = tr;
        return e;
    endfunction

    function automatic exp_t expN2(exp_t e, logic [15:0] mp, logic s, logic [7:0] tr);
        e.cMp2 = 1'b1; e.mp2 = mp;
        e.cS2  = 1'b1; e.s2  = s;
        e.cTr2 = 1'b1; e.tr2 = tr;
        return e;
    endfunction

    function automatic exp_t expRnd(exp_t e, logic [15:0] rnd);
        e.cRnd = 1'b1; e.rnd = rnd;
        return e;
    endfunction

    function automatic exp_t expSt(exp_t e, logic st);
        e.cSt = 1'b1; e.st = st;
        return e;
    endfunction

    function automatic exp_t expReset(logic st);
        exp_t e;
        e = '0;
        e = expRnd(e, 16'hACE1);
        e = expSt(e, st);
        e = expN1(e, 16'd0, 1'b0, 8'd0);
        e = expN2(e, 16'd0, 1'b0, 8'd0);
        return e;
    endfunction

    // Inputs are already set on the falling edge; expectation describes state after the next rise.
    task automatic applyStimulus(input exp_t e);
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, want);
        end
    endtask

    // Monitor: every edge yields a full set of outputs, sampled 1 time unit later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.cRnd) checkOutput("random_number", bus.random_number, e.rnd);
                if (e.cSt)  checkOutput("spike_train", {15'd0, bus.spike_train}, {15'd0, e.st});
                if (e.cMp1) checkOutput("memb_potential_out1", bus.memb_potential_out1, e.mp1);
                if (e.cS1)  checkOutput("spike_out1", {15'd0, bus.spike_out1}, {15'd0, e.s1});
                if (e.cTr1) checkOutput("tr1", {8'd0, bus.tr1}, {8'd0, e.tr1});
                if (e.cMp2) checkOutput("memb_potential_out2", bus.memb_potential_out2, e.mp2);
                if (e.cS2)  checkOutput("spike_out2", {15'd0, bus.spike_out2}, {15'd0, e.s2});
                if (e.cTr2) checkOutput("tr2", {8'd0, bus.tr2}, {8'd0, e.tr2});
            end
        end
    end

    initial begin
        exp_t e;
        logic [15:0] mp1Tab [4];
        logic        s1Tab  [4];
        logic [15:0] mp2Tab [11];
        mp1Tab = '{16'd2, 16'd4, 16'd0, 16'd0};
        s1Tab  = '{1'b0, 1'b0, 1'b1, 1'b0};
        mp2Tab = '{16'd0, 16'd0, 16'd0, 16'd3, 16'd2, 16'd1, 16'd0, 16'd3, 16'd2, 16'd1, 16'd0};

        rst = 1'b1;
        bus.pixel_value = 16'd0;
        bus.weight1 = 16'd0;      bus.weight2 = 16'd0;
        bus.threshold1 = 16'hFFFF; bus.threshold2 = 16'hFFFF;
        bus.leak_value1 = 16'd0;  bus.leak_value2 = 16'd0;
        bus.tref1 = 8'd0;         bus.tref2 = 8'd0;

        applyStimulus(expReset(1'b0));
        applyStimulus(expReset(1'b0));

        // LFSR steps from the seed; encoder compare is inclusive at the boundary
        rst = 1'b0;
        bus.pixel_value = 16'h59C3;
        e = '0; e = expRnd(e, 16'h59C3); e = expSt(e, 1'b1);
        applyStimulus(e);
        bus.pixel_value = 16'hB386;
        e = '0; e = expRnd(e, 16'hB387); e = expSt(e, 1'b0);
        applyStimulus(e);

        // Zero intensity never spikes, so neither neuron moves
        bus.pixel_value = 16'd0;
        bus.weight1 = 16'd3; bus.threshold1 = 16'd5; bus.leak_value1 = 16'd1;
        bus.weight2 = 16'd3; bus.threshold2 = 16'd5; bus.leak_value2 = 16'd1;
        for (int i = 0; i < 50; i++) begin
            e = '0; e = expSt(e, 1'b0);
            e = expN1(e, 16'd0, 1'b0, 8'd0);
            e = expN2(e, 16'd0, 1'b0, 8'd0);
            applyStimulus(e);
        end

        // Full intensity: neuron 1 fires every 4 cycles, neuron 2 only leaks
        bus.pixel_value = 16'hFFFF;
        bus.tref1 = 8'd1;
        bus.weight2 = 16'd4; bus.tref2 = 8'd0;
        for (int k = 0; k < 11; k++) begin
            e = '0; e = expSt(e, 1'b1);
            e = expN1(e, mp1Tab[k % 4], s1Tab[k % 4], {7'd0, s1Tab[k % 4]});
            e = expN2(e, mp2Tab[k], 1'b0, 8'd0);
            applyStimulus(e);
        end

        // Reset lands while neuron 1 is refractory
        rst = 1'b1;
        applyStimulus(expReset(1'b1));
        rst = 1'b0;

        // Stronger second synapse: neuron 2 fires one cycle after each neuron 1 spike
        bus.weight2 = 16'd6;
        for (int k = 0; k < 12; k++) begin
            e = '0;
            e = expN1(e, mp1Tab[k % 4], s1Tab[k % 4], {7'd0, s1Tab[k % 4]});
            e = expN2(e, 16'd0, (k % 4) == 3, 8'd0);
            applyStimulus(e);
        end

        rst = 1'b1;
        applyStimulus(expReset(1'b1));
        rst = 1'b0;

        // Saturation at the top of the range
        bus.weight2 = 16'd0;
        bus.weight1 = 16'hFFFF; bus.threshold1 = 16'hFFFF;
        bus.leak_value1 = 16'd0; bus.tref1 = 8'd0;
        e = '0; applyStimulus(expN1(e, 16'd0, 1'b1, 8'd0));
        bus.weight1 = 16'h8000; bus.leak_value1 = 16'd2;
        e = '0; applyStimulus(expN1(e, 16'h7FFE, 1'b0, 8'd0));
        e = '0; applyStimulus(expN1(e, 16'hFFFC, 1'b0, 8'd0));
        e = '0; applyStimulus(expN1(e, 16'd0, 1'b1, 8'd0));

        // Leak larger than the potential clamps at zero
        bus.weight1 = 16'd8; bus.leak_value1 = 16'd5;
        e = '0; applyStimulus(expN1(e, 16'd3, 1'b0, 8'd0));
        bus.pixel_value = 16'd0;
        e = '0; e = expSt(e, 1'b0); applyStimulus(expN1(e, 16'd0, 1'b0, 8'd0));
        e = '0; applyStimulus(expN1(e, 16'd0, 1'b0, 8'd0));

        // Zero threshold fires on every non-refractory cycle
        bus.threshold1 = 16'd0; bus.weight1 = 16'd0; bus.tref1 = 8'd2;
        e = '0; applyStimulus(expN1(e, 16'd0, 1'b1, 8'd2));
        e = '0; applyStimulus(expN1(e, 16'd0, 1'b0, 8'd1));
        e = '0; applyStimulus(expN1(e, 16'd0, 1'b0, 8'd0));
        e = '0; applyStimulus(expN1(e, 16'd0, 1'b1, 8'd2));

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_drain got=%0d want=0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
